// File: rtl/t3_align_shift.sv
// t3_align_shift -- two-stage alignment shifter for the MAF datapath (T3_1/T3_2).
//
// Shifts the pre-placed addend field right by the exponent difference d,
// per precision mode, and hands the aligned word, mode, signs and d to T4_1.
//   T3_1: coarse shift by multiples of 16 (d[6:4], dual lanes d[5:4]).
//   T3_2: fine shift by d[3:0] (dual high lane d[9:6]).
// Both stages use valid/ready flow control. Depth is 2 and throughput is 1 beat/cycle.
// An empty T3_2 slot accepts from T3_1 even while downstream is stalled.
//
// Modes (cont): 000 double [73:0], 001 dual (high [69:35], low [34:0]),
//               010 single [73:26]; anything else is invalid and yields sh_reg=0.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            input handshake (in_ready is combinational)
//   cont_in, addend_in, d_in     mode, unshifted addend, shift amount
//   S_{A,B,C}[_H]_in             operand signs (low/only lane, high lane)
//   out_valid/out_ready          output handshake
//   sh_reg_T3_2                  aligned addend
//   cont/d/S_*_T3_2              delayed side-band
//   sticky_T3_2, sticky_h_T3_2   OR of shifted-out bits (low/only, high lane)
//
// Build option: `define ALIGN_STICKY_EN to generate the sticky logic.
// When the macro is not defined, both sticky outputs are tied to 0.

module t3_align_rsh #(
  parameter int W  = 74,
  parameter int AW = 7
) (
  input  logic [W-1:0]  x,
  input  logic [AW-1:0] sh,
  output logic [W-1:0]  y
`ifdef ALIGN_STICKY_EN
  , output logic        lost
`endif
);
  assign y = x >> sh;
`ifdef ALIGN_STICKY_EN
  localparam logic [W-1:0] ONES = '1;
  // An amount at or above W makes the mask all ones, so the whole field counts as lost.
  assign lost = |(x & ~(ONES << sh));
`endif
endmodule

module t3_align_shift #(
  parameter int W_SH = 74,
  parameter int W_D  = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      cont_in,
  input  logic [W_SH-1:0] addend_in,
  input  logic [W_D-1:0]  d_in,
  input  logic            S_A_in,
  input  logic            S_B_in,
  input  logic            S_C_in,
  input  logic            S_A_H_in,
  input  logic            S_B_H_in,
  input  logic            S_C_H_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W_SH-1:0] sh_reg_T3_2,
  output logic [2:0]      cont_T3_2,
  output logic [W_D-1:0]  d_T3_2,
  output logic            S_A_T3_2,
  output logic            S_B_T3_2,
  output logic            S_C_T3_2,
  output logic            S_A_H_T3_2,
  output logic            S_B_H_T3_2,
  output logic            S_C_H_T3_2,
  output logic            sticky_T3_2,
  output logic            sticky_h_T3_2
);
  localparam int STAGES    = 2;
  localparam int NUM_LANES = 2;              // dual-mode lanes
  localparam int W_LN      = 35;             // dual lane field width
  localparam int W_SGL     = 48;             // single field width
  localparam int SGL_LSB   = W_SH - W_SGL;   // single field sits at the top

  localparam logic [2:0] M_DBL  = 3'b000;
  localparam logic [2:0] M_DUAL = 3'b001;
  localparam logic [2:0] M_SGL  = 3'b010;

  typedef struct packed {
    logic [2:0]     cont;
    logic [W_D-1:0] d;
    logic           s_a, s_b, s_c, s_a_h, s_b_h, s_c_h;
  } meta_t;

  // ---------------- flow control ----------------
  logic [STAGES:1] vld_pipe;
  logic            s1_load, s2_load, s1_en, s2_en;

  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_load   = !vld_pipe[1] || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_pipe[2];
  assign s1_en     = s1_load && in_valid;
  assign s2_en     = s2_load && vld_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_load) vld_pipe[1] <= in_valid;
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // ---------------- T3_1: coarse shift ----------------
  meta_t                              meta_in, meta_1, meta_2;
  logic                               dbl0, sgl0, dual0, dbl1, sgl1, dual1;
  logic [W_SH-1:0]                    wide0, wide0_sh, word0_nx, word_1;
  logic [W_SH-1:0]                    wide1_sh, word1_nx, word_2;
  logic [NUM_LANES-1:0][W_LN-1:0]     ln0, ln0_sh, ln1, ln1_sh;
`ifdef ALIGN_STICKY_EN
  logic                               wide0_lost, wide1_lost;
  logic [NUM_LANES-1:0]               ln0_lost, ln1_lost;
`endif

  assign meta_in = '{cont: cont_in, d: d_in, s_a: S_A_in, s_b: S_B_in, s_c: S_C_in,
                     s_a_h: S_A_H_in, s_b_h: S_B_H_in, s_c_h: S_C_H_in};

  assign dbl0  = cont_in == M_DBL;
  assign sgl0  = cont_in == M_SGL;
  assign dual0 = cont_in == M_DUAL;

  // Single mode discards whatever sits below the field before shifting.
  assign wide0 = dbl0 ? addend_in :
                 sgl0 ? {addend_in[W_SH-1:SGL_LSB], {SGL_LSB{1'b0}}} : '0;
  assign ln0   = addend_in[2*W_LN-1:0];

  t3_align_rsh #(.W(W_SH), .AW(7)) u_wide_c (
    .x  (wide0),
    .sh ({d_in[6:4], 4'b0000}),
    .y  (wide0_sh)
`ifdef ALIGN_STICKY_EN
    , .lost (wide0_lost)
`endif
  );

  // ---------------- T3_2: fine shift (wide path) ----------------
  assign dbl1  = meta_1.cont == M_DBL;
  assign sgl1  = meta_1.cont == M_SGL;
  assign dual1 = meta_1.cont == M_DUAL;
  assign ln1   = word_1[2*W_LN-1:0];

  t3_align_rsh #(.W(W_SH), .AW(4)) u_wide_f (
    .x  (word_1),
    .sh (meta_1.d[3:0]),
    .y  (wide1_sh)
`ifdef ALIGN_STICKY_EN
    , .lost (wide1_lost)
`endif
  );

  // Each dual lane shifts within its own 35 bits, so nothing crosses into the other lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    t3_align_rsh #(.W(W_LN), .AW(6)) u_c (
      .x  (ln0[l]),
      .sh ({d_in[6*l+5 -: 2], 4'b0000}),
      .y  (ln0_sh[l])
`ifdef ALIGN_STICKY_EN
      , .lost (ln0_lost[l])
`endif
    );
    t3_align_rsh #(.W(W_LN), .AW(4)) u_f (
      .x  (ln1[l]),
      .sh (meta_1.d[6*l+3 -: 4]),
      .y  (ln1_sh[l])
`ifdef ALIGN_STICKY_EN
      , .lost (ln1_lost[l])
`endif
    );
  end

  // Reassemble the word by mode. In single mode, bits that slide below the field are dropped.
  always_comb begin
    word0_nx = '0;
    if (dbl0)       word0_nx = wide0_sh;
    else if (sgl0)  word0_nx = {wide0_sh[W_SH-1:SGL_LSB], {SGL_LSB{1'b0}}};
    else if (dual0) word0_nx = {{(W_SH-2*W_LN){1'b0}}, ln0_sh};
  end

  always_comb begin
    word1_nx = '0;
    if (dbl1)       word1_nx = wide1_sh;
    else if (sgl1)  word1_nx = {wide1_sh[W_SH-1:SGL_LSB], {SGL_LSB{1'b0}}};
    else if (dual1) word1_nx = {{(W_SH-2*W_LN){1'b0}}, ln1_sh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_1 <= '0;
      word_1 <= '0;
      meta_2 <= '0;
      word_2 <= '0;
    end else begin
      if (s1_en) begin
        meta_1 <= meta_in;
        word_1 <= word0_nx;
      end
      if (s2_en) begin
        meta_2 <= meta_1;
        word_2 <= word1_nx;
      end
    end
  end

  // ---------------- sticky ----------------
`ifdef ALIGN_STICKY_EN
  logic [1:0] st0_nx, st_1, st1_nx, st_2;   // [1] high lane, [0] low/only lane

  always_comb begin
    st0_nx = '0;
    if (dbl0)       st0_nx[0] = wide0_lost;
    else if (sgl0)  st0_nx[0] = wide0_lost | (|wide0_sh[SGL_LSB-1:0]);
    else if (dual0) st0_nx    = ln0_lost;
  end

  always_comb begin
    st1_nx = '0;
    if (dbl1)       st1_nx[0] = st_1[0] | wide1_lost;
    else if (sgl1)  st1_nx[0] = st_1[0] | wide1_lost | (|wide1_sh[SGL_LSB-1:0]);
    else if (dual1) st1_nx    = st_1 | ln1_lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_1 <= '0;
      st_2 <= '0;
    end else begin
      if (s1_en) st_1 <= st0_nx;
      if (s2_en) st_2 <= st1_nx;
    end
  end

  assign sticky_T3_2   = st_2[0];
  assign sticky_h_T3_2 = st_2[1];
`else
  assign sticky_T3_2   = 1'b0;
  assign sticky_h_T3_2 = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign sh_reg_T3_2 = word_2;
  assign cont_T3_2   = meta_2.cont;
  assign d_T3_2      = meta_2.d;
  assign S_A_T3_2    = meta_2.s_a;
  assign S_B_T3_2    = meta_2.s_b;
  assign S_C_T3_2    = meta_2.s_c;
  assign S_A_H_T3_2  = meta_2.s_a_h;
  assign S_B_H_T3_2  = meta_2.s_b_h;
  assign S_C_H_T3_2  = meta_2.s_c_h;

endmodule

// File: tb/tb_t3_align_shift.sv
// Self-checking bench for t3_align_shift: directed mode/boundary beats, back-pressure,
// randomized traffic against a saturating-shift reference model, and mid-flight reset.
module tb_t3_align_shift;
`ifdef ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  cont_in = '0;
  logic [73:0] addend_in = '0;
  logic [11:0] d_in = '0;
  logic [5:0]  sg = '0;   // {A, B, C, A_H, B_H, C_H}
  wire         in_ready, out_valid, st_o, sth_o;
  wire  [73:0] sh_o;
  wire  [2:0]  cont_o;
  wire  [11:0] d_o;
  wire  [5:0]  sg_o;
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  t3_align_shift dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cont_in(cont_in), .addend_in(addend_in), .d_in(d_in),
    .S_A_in(sg[5]), .S_B_in(sg[4]), .S_C_in(sg[3]),
    .S_A_H_in(sg[2]), .S_B_H_in(sg[1]), .S_C_H_in(sg[0]),
    .out_valid(out_valid), .out_ready(out_ready), .sh_reg_T3_2(sh_o),
    .cont_T3_2(cont_o), .d_T3_2(d_o),
    .S_A_T3_2(sg_o[5]), .S_B_T3_2(sg_o[4]), .S_C_T3_2(sg_o[3]),
    .S_A_H_T3_2(sg_o[2]), .S_B_H_T3_2(sg_o[1]), .S_C_H_T3_2(sg_o[0]),
    .sticky_T3_2(st_o), .sticky_h_T3_2(sth_o)
  );

  typedef struct packed {
    logic [2:0]  cont;
    logic [11:0] d;
    logic [5:0]  sg;
    logic [73:0] sh;
    logic        st;
    logic        sth;
  } beat_t;

  beat_t act;
  assign act = {cont_o, d_o, sg_o, sh_o, st_o, sth_o};
  beat_t sb[$];

  // Field shifted right by amt in one step: {result, sticky}; amt >= fw saturates.
  function automatic logic [128:0] fshift(logic [127:0] f, int amt, int fw);
    logic [127:0] m;
    if (amt >= fw) return {128'b0, |f};
    m = (128'b1 << amt) - 128'b1;
    return {f >> amt, |(f & m)};
  endfunction

  function automatic beat_t model(logic [2:0] c, logic [73:0] a, logic [11:0] dd, logic [5:0] s);
    beat_t e;
    logic [128:0] r, rh;
    e = '0; e.cont = c; e.d = dd; e.sg = s;
    case (c)
      3'b000: begin
        r = fshift({54'b0, a}, int'(dd[6:0]), 74);
        e.sh = r[74:1]; e.st = r[0];
      end
      3'b010: begin
        r = fshift({80'b0, a[73:26]}, int'(dd[6:0]), 48);
        e.sh = {r[48:1], 26'b0}; e.st = r[0];
      end
      3'b001: begin
        r  = fshift({93'b0, a[34:0]}, int'(dd[5:0]), 35);
        rh = fshift({93'b0, a[69:35]}, int'(dd[11:6]), 35);
        e.sh = {4'b0, rh[35:1], r[35:1]}; e.st = r[0]; e.sth = rh[0];
      end
      default: ;
    endcase
    if (!STK) begin e.st = 1'b0; e.sth = 1'b0; end
    return e;
  endfunction

  logic [6:0] bnd7 [9] = '{7'd0, 7'd1, 7'd15, 7'd16, 7'd47, 7'd48, 7'd73, 7'd74, 7'd127};
  logic [5:0] bnd6 [7] = '{6'd0, 6'd1, 6'd15, 6'd16, 6'd34, 6'd35, 6'd63};

  task automatic rand_beat();
    logic [95:0] r;
    int m;
    r = {$urandom(), $urandom(), $urandom()};
    m = $urandom_range(0, 9);
    cont_in = (m < 3) ? 3'b000 : (m < 6) ? 3'b001 : (m < 9) ? 3'b010 : 3'($urandom_range(3, 7));
    if ($urandom_range(0, 2) == 0) addend_in = 74'h1 << $urandom_range(0, 73);
    else addend_in = r[73:0];
    d_in = 12'($urandom());
    if ($urandom_range(0, 1) == 1) begin
      if (cont_in == 3'b001) d_in = {bnd6[$urandom_range(0, 6)], bnd6[$urandom_range(0, 6)]};
      else d_in[6:0] = bnd7[$urandom_range(0, 8)];
    end
    sg = 6'($urandom());
  endtask

  // One beat into an empty pipe with out_ready=1; lat counts edges until out_valid.
  task automatic run_one(input logic [2:0] c, input logic [73:0] a, input logic [11:0] dd,
                         input logic [5:0] s, output int lat);
    cont_in = c; addend_in = a; d_in = dd; sg = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (act !== '0) $display("FAIL reset_outputs: got %h want 0", act); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || act !== '0)
      $display("FAIL reset_release: valid %b out %h want 0/0", out_valid, act); else passed++;
  endtask

  task automatic test_double();
    int lat;
    beat_t e;
    logic [73:0] a;
    a = 74'h1 << 73;
    run_one(3'b000, a, 12'd1, 6'b101010, lat);
    total++; if (lat != 2 || out_valid !== 1'b1) $display("FAIL dbl_latency: got %0d want 2", lat); else passed++;
    total++; if (sh_o !== (74'h1 << 72) || st_o !== 1'b0)
      $display("FAIL dbl_shift1: got %h/%b want %h/0", sh_o, st_o, 74'h1 << 72); else passed++;
    e = model(3'b000, a, 12'd1, 6'b101010);
    total++; if (act !== e) $display("FAIL dbl_shift1_all: got %h want %h", act, e); else passed++;
    run_one(3'b000, 74'h3, 12'd1, 6'b000001, lat);
    total++; if (sh_o !== 74'h1 || st_o !== STK || sth_o !== 1'b0)
      $display("FAIL dbl_sticky: got %h/%b/%b want 1/%b/0", sh_o, st_o, sth_o, STK); else passed++;
    run_one(3'b000, 74'h1, 12'd74, 6'b0, lat);
    total++; if (sh_o !== '0 || st_o !== STK)
      $display("FAIL dbl_sat74: got %h/%b want 0/%b", sh_o, st_o, STK); else passed++;
    run_one(3'b000, 74'h1, 12'd0, 6'b0, lat);
    total++; if (sh_o !== 74'h1 || st_o !== 1'b0)
      $display("FAIL dbl_amt0: got %h/%b want 1/0", sh_o, st_o); else passed++;
    a = {74{1'b1}};
    run_one(3'b000, a, 12'd127, 6'b111111, lat);
    e = model(3'b000, a, 12'd127, 6'b111111);
    total++; if (act !== e || sh_o !== '0) $display("FAIL dbl_sat127: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_dual();
    int lat;
    beat_t e;
    logic [73:0] a;
    a = {4'b0, 35'h1, 35'h4_0000_0000};
    run_one(3'b001, a, {6'd1, 6'd1}, 6'b010101, lat);
    total++; if (sh_o[69:35] !== '0 || sth_o !== STK)
      $display("FAIL dual_high: got %h/%b want 0/%b", sh_o[69:35], sth_o, STK); else passed++;
    total++; if (sh_o !== (74'h1 << 33) || st_o !== 1'b0)
      $display("FAIL dual_low_isolation: got %h/%b want %h/0", sh_o, st_o, 74'h1 << 33); else passed++;
    a = {4'hF, {70{1'b1}}};
    run_one(3'b001, a, {6'd35, 6'd16}, 6'b0, lat);
    e = model(3'b001, a, {6'd35, 6'd16}, 6'b0);
    total++; if (act !== e || sh_o[73:70] !== 4'b0) $display("FAIL dual_sat: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_single();
    int lat;
    logic [73:0] a;
    a = (74'h1 << 73) | 74'h3FF_FFFF;   // junk below the field must not appear
    run_one(3'b010, a, 12'd20, 6'b110000, lat);
    total++; if (sh_o !== (74'h1 << 53) || st_o !== 1'b0 || sth_o !== 1'b0)
      $display("FAIL sgl_shift20: got %h/%b want %h/0", sh_o, st_o, 74'h1 << 53); else passed++;
    run_one(3'b010, 74'h1 << 26, 12'd1, 6'b0, lat);
    total++; if (sh_o !== '0 || st_o !== STK)
      $display("FAIL sgl_field_edge: got %h/%b want 0/%b", sh_o, st_o, STK); else passed++;
    run_one(3'b011, a, 12'd20, 6'b100001, lat);
    total++; if (sh_o !== '0 || cont_o !== 3'b011 || d_o !== 12'd20 || sg_o !== 6'b100001 || st_o !== 1'b0 || sth_o !== 1'b0)
      $display("FAIL invalid_mode: got %h want sh=0 cont=3 d=014 sg=21 st=0", act); else passed++;
  endtask

  task automatic test_back_pressure();
    int acc, got;
    beat_t e, held;
    sb.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0; acc = 0; held = '0;
    for (int k = 0; k < 6; k++) begin
      rand_beat(); in_valid = 1'b1;
      #1;
      if (acc >= 2) begin
        total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0 (cycle %0d)", in_ready, k); else passed++;
      end
      if (k == 3) held = act;
      if (k == 5) begin
        total++; if (out_valid !== 1'b1 || act !== held)
          $display("FAIL bp_stall_hold: got %h want %h", act, held); else passed++;
      end
      if (in_valid && in_ready) begin sb.push_back(model(cont_in, addend_in, d_in, sg)); acc++; end
      @(posedge clk); #1;
    end
    total++; if (acc != 2) $display("FAIL bp_accept_count: got %0d want 2", acc); else passed++;
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (acc < 4) begin rand_beat(); in_valid = 1'b1; end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        total++;
        if (sb.size() == 0) $display("FAIL bp_extra_beat: got %h want none", act);
        else begin
          e = sb.pop_front();
          if (act !== e) $display("FAIL bp_order: got %h want %h", act, e); else passed++;
        end
        got++;
      end
      if (in_valid && in_ready) begin sb.push_back(model(cont_in, addend_in, d_in, sg)); acc++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (got != 4) $display("FAIL bp_drain: got %0d beats want 4", got); else passed++;
  endtask

  task automatic test_random();
    beat_t e, held;
    bit stalled;
    int sent, rcv;
    sb.delete(); sent = 0; rcv = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (stalled) begin
        total++; if (out_valid !== 1'b1 || act !== held)
          $display("FAIL rnd_stall_hold: got %h want %h", act, held); else passed++;
      end
      out_ready = (cyc >= 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (sent < 400 && cyc < 500 && $urandom_range(0, 4) != 0) begin rand_beat(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL rnd_extra_beat: got %h want none", act);
        else begin
          e = sb.pop_front();
          if (act !== e) $display("FAIL rnd_beat: got %h want %h", act, e); else passed++;
        end
        rcv++;
      end
      stalled = out_valid && !out_ready;
      held = act;
      if (in_valid && in_ready) begin sb.push_back(model(cont_in, addend_in, d_in, sg)); sent++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (sb.size() != 0 || rcv != sent)
      $display("FAIL rnd_count: got %0d beats want %0d", rcv, sent); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    beat_t e;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin rand_beat(); in_valid = 1'b1; @(posedge clk); #1; end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL rst_mid_setup: got %b want 1", out_valid); else passed++;
    rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || sh_o !== '0)
      $display("FAIL rst_mid_async: got %b/%h want 0/0", out_valid, sh_o); else passed++;
    total++; if (act !== '0) $display("FAIL rst_mid_clear: got %h want 0", act); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_stale: got %b want 0 (cycle %0d)", out_valid, k); else passed++;
    end
    run_one(3'b000, 74'h1 << 40, 12'd17, 6'b011011, lat);
    e = model(3'b000, 74'h1 << 40, 12'd17, 6'b011011);
    total++; if (lat != 2 || act !== e) $display("FAIL rst_mid_resume: got %h want %h", act, e); else passed++;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_double();
    test_dual();
    test_single();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/t3_align_shift.md
Name: t3_align_shift

Overview:
- Two-stage pipelined alignment shifter for the MAF datapath, stages T3_1 and T3_2.
- Takes the pre-placed, unshifted addend field and shifts it right by the exponent difference, per precision mode.
- Produces the registered sh_reg_T3_2 word, mode, operand signs and d that the T4_1 adder-input stage consumes.
- Carries valid/ready flow control so the stage can stall under back-pressure.

Parameters:
- W_SH, 74: width of the shift field / sh_reg output.
- W_D, 12: width of the exponent-difference word d.

Ports:
- clk  input  1  clock, all flops rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- cont_in  input  3  mode: 000 double, 001 dual-single, 010 single, other = invalid
- addend_in  input  74  unshifted addend. Double: bits [73:0]. Single: bits [73:26]. Dual: high lane [69:35], low lane [34:0].
- d_in  input  12  shift amount. Double/single: d[6:0]. Dual: high lane d[11:6], low lane d[5:0].
- S_A_in, S_B_in, S_C_in  input  1 each  signs, low/only lane
- S_A_H_in, S_B_H_in, S_C_H_in  input  1 each  signs, high lane (dual)
- out_valid  output  1  T3_2 register valid
- out_ready  input  1  downstream accepts
- sh_reg_T3_2  output  74  aligned addend
- cont_T3_2  output  3  mode, delayed
- d_T3_2  output  12  d_in, delayed, unmodified
- S_A_T3_2, S_B_T3_2, S_C_T3_2, S_A_H_T3_2, S_B_H_T3_2, S_C_H_T3_2  output  1 each  signs, delayed
- sticky_T3_2  output  1  OR of bits shifted out, low/only lane
- sticky_h_T3_2  output  1  OR of bits shifted out, high lane

Behaviour:
- Reset (async, rst_n=0): both stage valids=0 and all data registers=0. Outputs read out_valid=0, sh_reg=0, cont=0, d=0, all signs=0, both sticky=0. The release edge has no other effect.
- Latency: fixed 2 cycles from an accepted beat (in_valid&in_ready) to out_valid, with no stalls.
- Stage advance:
  - s2 loads when !s2_valid or out_ready.
  - s1 loads when !s1_valid or s2 loads.
  - in_ready = !s1_valid or s2 loads (combinational).
  - Full throughput of 1 beat/cycle.
  - Bubbles collapse: an empty s2 accepts s1 even while out_ready=0.
- Stall: while out_valid=1 and out_ready=0, every T3_2 output holds stable.
- Ordering: in-order, no drop, no duplication. Depth 2.
- Stage T3_1 (coarse shift):
  - Register mode, signs and d.
  - Shift each lane field right by 16*amt[6:4] (dual: 16*amt[5:4]).
  - Accumulate a partial sticky from the bits shifted out.
- Stage T3_2 (fine shift):
  - Shift right by amt[3:0].
  - OR the dropped bits into the sticky.
- Field widths: double 74 bits, single 48 bits, dual 35 bits per lane.
- Lane isolation in dual mode: a lane never shifts bits into the other lane.
- Bits outside the active field:
  - Single mode: [25:0]=0.
  - Dual mode: [73:70]=0.
- Saturation: shift amount ≥ field width gives field=0 and sticky = OR of the entire field. Amount 0 gives field unchanged and sticky=0.
- Invalid mode (011..111): sh_reg=0, both sticky=0. Signs, d and cont still pass through.
- sticky_h is 0 in all modes except dual.
- Mid-operation reset discards all in-flight beats immediately.

Optional Feature:
- ALIGN_STICKY_EN defined: sticky_T3_2 and sticky_h_T3_2 are computed as above.
- ALIGN_STICKY_EN undefined: both outputs are tied to 0, and the sticky accumulation logic and flops are removed. All other behaviour is identical.

Test Plan:
- Double shift by 1:
  - cont=000, addend=74'h1<<73, d=12'd1 -> 2 cycles later out_valid=1, sh_reg=74'h1<<72, sticky=0.
  - Then addend=74'h3, d=12'd1 -> sh_reg=74'h1, sticky=1.
- Double saturation: cont=000, addend=74'h1, d=12'd74 -> sh_reg=0, sticky=1. Same beat with d=0 -> sh_reg=74'h1, sticky=0.
- Dual lane isolation:
  - cont=001, high lane=35'h1, low lane=35'h4_0000_0000 (bit 34), d={6'd1,6'd1}.
  - -> high lane=0, sticky_h=1; low lane bit 33 set, sticky=0. Bit 34 stays clear (no cross-lane leak).
- Single field:
  - cont=010, addend[73]=1, d=12'd20 -> sh_reg bit 53 set, [25:0]=0.
  - cont=011 with the same addend -> sh_reg=0, cont_T3_2=011.
- Back-pressure: 4 consecutive beats with out_ready=0 from cycle 0 -> in_ready=0 after 2 beats accepted. Raise out_ready -> beats emerge in order, none lost, outputs stable while stalled.
- Reset mid-flight: 2 beats in flight, pulse rst_n low for 1 cycle -> out_valid=0 and sh_reg=0 immediately (asynchronously). No stale beat appears after release.
